if_queue: RTL and testbench

IF_QUEUE -- requirements
Module: if_queue

---
 rtl/if_queue.sv | 93 +++++++++
 tb/tb_if_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_queue.sv
// Instruction fetch queue: circular buffer of {addr, inst} pairs between Fetch and Decode.
// Optional predecode output is_branch is enabled by defining IFQ_PREDECODE_EN.
module if_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           addr,
    input  logic [W-1:0]           inst_in,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [W-1:0]           inst_out,
    output logic [W-1:0]           pc_out,
    output logic                   hold,
    output logic [$clog2(DEPTH):0] count
`ifdef IFQ_PREDECODE_EN
    ,
    output logic                   is_branch
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

    logic [W-1:0]  addr_mem [DEPTH];
    logic [W-1:0]  inst_mem [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    // A full queue never accepts a push, even when the head is popped the same edge.
    assign push = (count_q != Full) && !flush;
    assign pop  = (count_q != '0) && out_ready && !flush;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + 1'b1;
            end
            if (pop) begin
                rp_d = rp_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; stale contents are masked by out_valid below.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wp_q] <= addr;
            inst_mem[wp_q] <= inst_in;
        end
    end

    assign out_valid = (count_q != '0);
    assign hold      = (count_q == Full);
    assign count     = count_q;
    assign pc_out    = out_valid ? addr_mem[rp_q] : '0;
    assign inst_out  = out_valid ? inst_mem[rp_q] : '0;

`ifdef IFQ_PREDECODE_EN
    // Opcode 6'b000100 is beq.
    assign is_branch = out_valid && (inst_out[31:26] == 6'b000100);
`endif

endmodule

// File: tb/tb_if_queue.sv
// Scoreboard bench for if_queue: driver queues expected entries, negedge monitor checks pops.
module tb_if_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] inst_in;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        hold;
    logic [2:0]  count;
`ifdef IFQ_PREDECODE_EN
    logic        is_branch;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   mdl_cnt  = 0;
    ent_t exp_q[$];

    if_queue #(
        .DEPTH (DEPTH),
        .W     (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .inst_in   (inst_in),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .inst_out  (inst_out),
        .pc_out    (pc_out),
        .hold      (hold),
        .count     (count)
`ifdef IFQ_PREDECODE_EN
        ,
        .is_branch (is_branch)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(mdl_cnt));
        check({tag, "_valid"}, 32'(out_valid), 32'(mdl_cnt != 0));
        check({tag, "_hold"}, 32'(hold), 32'(mdl_cnt == DEPTH));
        if (mdl_cnt == 0) begin
            check({tag, "_pc_zero"}, pc_out, 32'h0);
            check({tag, "_inst_zero"}, inst_out, 32'h0);
        end else if (exp_q.size() != 0) begin
            check({tag, "_head_pc"}, pc_out, exp_q[0].pc);
            check({tag, "_head_inst"}, inst_out, exp_q[0].inst);
        end
    endtask

    // One clock edge with the given inputs; the model decides push/pop independently of the DUT.
    task automatic step(input logic [31:0] a, input logic [31:0] i, input logic rdy,
                        input logic fl, output logic pushed);
        logic do_push, do_pop;
        do_push = (mdl_cnt < DEPTH) && !fl;
        do_pop  = (mdl_cnt != 0) && rdy && !fl;
        addr      = a;
        inst_in   = i;
        out_ready = rdy;
        flush     = fl;
        if (fl) begin
            exp_q.delete();
        end
        if (do_push) begin
            exp_q.push_back('{pc: a, inst: i});
        end
        @(posedge clk);
        if (fl) begin
            mdl_cnt = 0;
        end else begin
            mdl_cnt = mdl_cnt + int'(do_push) - int'(do_pop);
        end
        #1;
        pushed = do_push;
        check_state("step");
    endtask

    // Monitor: a pop is committed at the next posedge when valid & ready & !flush.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected got pc=%h expected=no entry", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", pc_out, e.pc);
                    check("pop_inst", inst_out, e.inst);
                end
            end
        end
    end

    initial begin
        logic        p;
        int          n_pushed;
        logic [31:0] next_a;

        rst_n     = 1'b0;
        addr      = 32'h0;
        inst_in   = 32'h11111111;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_hold", 32'(hold), 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_inst", inst_out, 32'h0);
        #199;
        rst_n = 1'b1;

        // First edge after reset pushes addr 0.
        step(32'h0, 32'h11111111, 1'b0, 1'b0, p);
        check("first_pc", pc_out, 32'h0);
        check("first_inst", inst_out, 32'h11111111);
        check("first_count", 32'(count), 32'd1);

        for (int k = 1; k < 4; k++) begin
            step(32'(k), 32'hA000_0000 | 32'(k), 1'b0, 1'b0, p);
        end
        check("full_count", 32'(count), 32'd4);
        check("full_hold", 32'(hold), 32'd1);
        step(32'h4, 32'hA000_0004, 1'b0, 1'b0, p);
        check("full_blocked_push", 32'(p), 32'd0);
        check("full_head", pc_out, 32'h0);

        // Pop only while full, then push and pop together.
        step(32'h4, 32'hA000_0004, 1'b1, 1'b0, p);
        check("popfull_count", 32'(count), 32'd3);
        check("popfull_hold", 32'(hold), 32'd0);
        check("popfull_pc", pc_out, 32'h1);
        step(32'h4, 32'hA000_0004, 1'b1, 1'b0, p);
        check("pushpop_count", 32'(count), 32'd3);
        check("pushpop_pc", pc_out, 32'h2);

        // Flush overrides push and pop.
        step(32'h5, 32'hA000_0005, 1'b1, 1'b1, p);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        step(32'h2, 32'hB000_0002, 1'b0, 1'b0, p);
        check("postflush_pc", pc_out, 32'h2);
        check("postflush_inst", inst_out, 32'hB000_0002);

        // Stream 10 addresses with out_ready toggling; re-present when blocked.
        n_pushed = 0;
        next_a   = 32'h10;
        for (int it = 0; it < 40 && n_pushed < 10; it++) begin
            step(next_a, 32'hC000_0000 | next_a, it[0], 1'b0, p);
            if (p) begin
                n_pushed++;
                next_a = next_a + 1;
            end
        end
        check("stream_pushed", 32'(n_pushed), 32'd10);
        for (int it = 0; it < 20 && mdl_cnt != 0; it++) begin
            step(32'hDEAD_0000, 32'h0, 1'b1, 1'b1 && (mdl_cnt == 0), p);
            // Cancel the model push: drain must not add entries, so flush after.
            if (p) begin
                step(32'h0, 32'h0, 1'b0, 1'b1, p);
            end
        end
        check("drain_model_empty", 32'(mdl_cnt), 32'd0);
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-operation hides stale storage.
        step(32'h30, 32'hE000_0030, 1'b0, 1'b0, p);
        step(32'h31, 32'hE000_0031, 1'b0, 1'b0, p);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        mdl_cnt = 0;
        check("midrst_count", 32'(count), 32'h0);
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_pc", pc_out, 32'h0);
        check("midrst_inst", inst_out, 32'h0);
        #2;
        rst_n = 1'b1;
        step(32'h7, 32'hF000_0007, 1'b0, 1'b0, p);
        check("postrst_pc", pc_out, 32'h7);
        check("postrst_count", 32'(count), 32'd1);

`ifdef IFQ_PREDECODE_EN
        step(32'h0, 32'h0, 1'b0, 1'b1, p);
        check("pd_empty", 32'(is_branch), 32'd0);
        step(32'h8, 32'h10000002, 1'b0, 1'b0, p);
        check("pd_beq", 32'(is_branch), 32'd1);
        step(32'h9, 32'h00000000, 1'b1, 1'b0, p);
        check("pd_nop", 32'(is_branch), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
